rf_top: RTL

Integer register file with write-port scoreboard: the receiving end of the writeback stage's register-file write interface (`waddr`/`wdata`/`we`). It holds 31 general-purpose registers plus a hardwired x0, serves two combinational read ports to decode, and tracks per-register pending-write ("busy") bits so decode can stall on RAW hazards until writeback retires the write.

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 54 +++++
 rtl/rf_top.sv | 113 +++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared sizes, types and constants for the integer register file
package rf_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned NumRegs   = 32;
  localparam int unsigned AddrWidth = $clog2(NumRegs);

  typedef logic [AddrWidth-1:0] rf_addr_t;
  typedef logic [DataWidth-1:0] rf_data_t;

  localparam rf_addr_t RfZeroAddr = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write (busy) tracking
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   issue_rd_i, issue_we_i   destination of the instruction issuing this cycle
//   waddr_i, we_i            writeback retiring a write
//   flush_i                  drop every pending write
//   busy_o                   busy vector, bit 0 always 0
module rf_scoreboard #(
  parameter int unsigned NumRegs   = rf_pkg::NumRegs,
  parameter int unsigned AddrWidth = rf_pkg::AddrWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] issue_rd_i,
  input  logic                 issue_we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic                 we_i,
  input  logic                 flush_i,
  output logic [NumRegs-1:0]   busy_o
);

  logic [NumRegs-1:0] busy_d, busy_q;

  // Clear is applied before set so a same-cycle issue to the register being
  // retired keeps it busy: the issuing instruction is the younger producer.
  // Addresses outside 1..NumRegs-1 never match a bit, so they are ignored.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      for (int i = 1; i < int'(NumRegs); i++) begin
        if (we_i && (waddr_i == AddrWidth'(i))) begin
          busy_d[i] = 1'b0;
        end
        if (issue_we_i && (issue_rd_i == AddrWidth'(i))) begin
          busy_d[i] = 1'b1;
        end
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/rf_top.sv
// rtl/rf_top.sv - 31-entry integer register file with hardwired x0 and busy scoreboard
// Optional feature macro: RF_WRITE_BYPASS_EN (same-cycle write-to-read forwarding)
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   raddr_a_i/rdata_a_o/rbusy_a_o  read port A: address, data, pending-write flag
//   raddr_b_i/rdata_b_o/rbusy_b_o  read port B: address, data, pending-write flag
//   waddr_i, wdata_i, we_i         writeback write port
//   issue_rd_i, issue_we_i         destination claimed by the issuing instruction
//   flush_i                        drop all pending writes
//   busy_o                         full busy vector, bit 0 always 0
module rf_top
  import rf_pkg::RfZeroAddr;
#(
  parameter int unsigned DataWidth = rf_pkg::DataWidth,
  parameter int unsigned NumRegs   = rf_pkg::NumRegs,
  parameter int unsigned AddrWidth = rf_pkg::AddrWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] raddr_a_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic                 rbusy_a_o,
  input  logic [AddrWidth-1:0] raddr_b_i,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic                 rbusy_b_o,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] issue_rd_i,
  input  logic                 issue_we_i,
  input  logic                 flush_i,
  output logic [NumRegs-1:0]   busy_o
);

  // x0 has no storage; the array starts at index 1.
  logic [DataWidth-1:0] regs_d [1:NumRegs-1];
  logic [DataWidth-1:0] regs_q [1:NumRegs-1];
  logic                 wr_en;
  logic                 hit_a, hit_b;

  assign wr_en = we_i && (waddr_i != AddrWidth'(RfZeroAddr));

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < int'(NumRegs); i++) begin
      if (wr_en && (waddr_i == AddrWidth'(i))) begin
        regs_d[i] = wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  rf_scoreboard #(
    .NumRegs  (NumRegs),
    .AddrWidth(AddrWidth)
  ) u_scoreboard (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .issue_rd_i(issue_rd_i),
    .issue_we_i(issue_we_i),
    .waddr_i   (waddr_i),
    .we_i      (we_i),
    .flush_i   (flush_i),
    .busy_o    (busy_o)
  );

  // Read muxes: x0 and out-of-range addresses match no entry and read as 0 / not busy.
  always_comb begin
    rdata_a_o = '0;
    rbusy_a_o = 1'b0;
    rdata_b_o = '0;
    rbusy_b_o = 1'b0;
    hit_a     = 1'b0;
    hit_b     = 1'b0;
    for (int i = 1; i < int'(NumRegs); i++) begin
      if (raddr_a_i == AddrWidth'(i)) begin
        rdata_a_o = regs_q[i];
        rbusy_a_o = busy_o[i];
        hit_a     = 1'b1;
      end
      if (raddr_b_i == AddrWidth'(i)) begin
        rdata_b_o = regs_q[i];
        rbusy_b_o = busy_o[i];
        hit_b     = 1'b1;
      end
    end
`ifdef RF_WRITE_BYPASS_EN
    // Forward the retiring write; the register only stays busy if a new
    // producer claims it in this same cycle.
    if (hit_a && wr_en && (raddr_a_i == waddr_i)) begin
      rdata_a_o = wdata_i;
      rbusy_a_o = issue_we_i && (issue_rd_i == raddr_a_i);
    end
    if (hit_b && wr_en && (raddr_b_i == waddr_i)) begin
      rdata_b_o = wdata_i;
      rbusy_b_o = issue_we_i && (issue_rd_i == raddr_b_i);
    end
`else
    hit_a = hit_a;
    hit_b = hit_b;
`endif
  end

endmodule
